// File: rtl/l_next_fill_ctrl_if.sv
// Miss-request, next-level memory and cache-fill signals of the L1I fill controller.
// slave = controller side, master = cache/memory side.
interface l_next_fill_ctrl_if #(
   parameter int LADDRBITS = 26,
   parameter int LINEWORDS = 16
);
   logic                         req_valid;
   logic                         req_ready;
   logic [LADDRBITS-1:0]         req_laddr;
   logic                         flush;

   logic                         mem_req;
   logic                         mem_ack;
   logic [LADDRBITS-1:0]         mem_laddr;
   logic                         mem_rvalid;
   logic                         mem_rready;
   logic [31:0]                  mem_rdata;

   logic                         fill_valid;
   logic                         fill_ready;
   logic [LADDRBITS-1:0]         fill_laddr;
   logic [$clog2(LINEWORDS)-1:0] fill_idx;
   logic [31:0]                  fill_data;
   logic                         fill_last;

   logic [31:0]                  issue_count;
   logic [31:0]                  merge_count;

   modport slave (
      input  req_valid, req_laddr, flush, mem_ack, mem_rvalid, mem_rdata, fill_ready,
      output req_ready, mem_req, mem_laddr, mem_rready,
      output fill_valid, fill_laddr, fill_idx, fill_data, fill_last,
      output issue_count, merge_count
   );

   modport master (
      output req_valid, req_laddr, flush, mem_ack, mem_rvalid, mem_rdata, fill_ready,
      input  req_ready, mem_req, mem_laddr, mem_rready,
      input  fill_valid, fill_laddr, fill_idx, fill_data, fill_last,
      input  issue_count, merge_count
   );
endinterface

// File: rtl/l_next_fill_ctrl.sv
// Queues L1I line misses (merging duplicates), issues burst reads, streams beats to the fill port; mem_req 1 cycle after accept.
// Backpressure: req_ready = !full; mem_rready = !fill_valid || fill_ready through a one-beat output register.
module l_next_fill_ctrl #(
   parameter int DEPTH     = 4,
   parameter int LINEWORDS = 16,
   parameter int LADDRBITS = 26
) (
   input logic               clock,
   input logic               reset_n,
   l_next_fill_ctrl_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int IW = $clog2(LINEWORDS);

   typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

   typedef struct packed {
      logic                 vld;
      logic [LADDRBITS-1:0] laddr;
   } entry_t;

   entry_t               q [DEPTH];
   logic [PW-1:0]        head;
   logic [PW:0]          count;
   state_t               state;
   logic [IW-1:0]        beat_cnt;

   logic                 mem_req_r;
   logic [LADDRBITS-1:0] mem_laddr_r;
   logic                 fill_valid_r;
   logic                 fill_last_r;
   logic [LADDRBITS-1:0] fill_laddr_r;
   logic [IW-1:0]        fill_idx_r;
   logic [31:0]          fill_data_r;
   logic [31:0]          issue_cnt_r;
   logic [31:0]          merge_cnt_r;

   logic                 in_flight;
   logic                 accept;
   logic                 beat_xfer;
   logic                 last_xfer;
   logic                 hit;
   logic                 enq;
   logic                 merge;
   logic [DEPTH-1:0]     live;
   logic [PW:0]          cnt_f;
   logic [PW:0]          cnt_next;
   logic [PW-1:0]        tail;

   assign in_flight      = (state != IDLE);
   assign bus.req_ready  = (count != (PW+1)'(DEPTH));
   assign bus.mem_rready = !fill_valid_r || bus.fill_ready;
   assign accept         = bus.req_valid && bus.req_ready;
   assign beat_xfer      = (state == DATA) && bus.mem_rvalid && bus.mem_rready;
   assign last_xfer      = beat_xfer && (beat_cnt == IW'(LINEWORDS - 1));

   // Entries surviving this cycle's flush/pop; a head whose line just completed
   // no longer absorbs a new miss for the same address.
   always_comb begin
      hit  = 1'b0;
      live = '0;
      for (int i = 0; i < DEPTH; i++) begin
         live[i] = q[i].vld;
         if (PW'(i) == head) begin
            if (last_xfer || (bus.flush && !in_flight)) live[i] = 1'b0;
         end else if (bus.flush) begin
            live[i] = 1'b0;
         end
         if (live[i] && (q[i].laddr == bus.req_laddr)) hit = 1'b1;
      end
   end

   assign enq      = accept && !hit;
   assign merge    = accept && hit;
   assign cnt_f    = bus.flush ? {{PW{1'b0}}, in_flight} : count;
   assign tail     = head + cnt_f[PW-1:0];
   assign cnt_next = cnt_f - (PW+1)'(last_xfer) + (PW+1)'(enq);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!live[i]) q[i].vld <= 1'b0;
         end
         if (enq) q[tail] <= {1'b1, bus.req_laddr};
         if (last_xfer) head <= head + 1'b1;
         count <= cnt_next;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         beat_cnt     <= '0;
         mem_req_r    <= 1'b0;
         mem_laddr_r  <= '0;
         fill_valid_r <= 1'b0;
         fill_last_r  <= 1'b0;
         fill_laddr_r <= '0;
         fill_idx_r   <= '0;
         fill_data_r  <= '0;
         issue_cnt_r  <= '0;
         merge_cnt_r  <= '0;
      end else begin
         merge_cnt_r <= merge_cnt_r + 32'(merge);

         if (beat_xfer) begin
            fill_valid_r <= 1'b1;
            fill_data_r  <= bus.mem_rdata;
            fill_idx_r   <= beat_cnt;
            fill_laddr_r <= mem_laddr_r;
            fill_last_r  <= (beat_cnt == IW'(LINEWORDS - 1));
         end else if (bus.fill_ready) begin
            fill_valid_r <= 1'b0;
         end

         case (state)
            IDLE: begin
               // An accept into an empty queue bypasses straight to the memory port.
               if (cnt_f != '0) begin
                  state       <= REQ;
                  mem_req_r   <= 1'b1;
                  mem_laddr_r <= q[head].laddr;
               end else if (enq) begin
                  state       <= REQ;
                  mem_req_r   <= 1'b1;
                  mem_laddr_r <= bus.req_laddr;
               end
            end
            REQ: begin
               if (bus.mem_ack) begin
                  state       <= DATA;
                  mem_req_r   <= 1'b0;
                  beat_cnt    <= '0;
                  issue_cnt_r <= issue_cnt_r + 32'd1;
               end
            end
            DATA: begin
               if (beat_xfer) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (last_xfer) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_req     = mem_req_r;
   assign bus.mem_laddr   = mem_laddr_r;
   assign bus.fill_valid  = fill_valid_r;
   assign bus.fill_laddr  = fill_laddr_r;
   assign bus.fill_idx    = fill_idx_r;
   assign bus.fill_data   = fill_data_r;
   assign bus.fill_last   = fill_last_r;
   assign bus.issue_count = issue_cnt_r;
   assign bus.merge_count = merge_cnt_r;
endmodule

// File: tb/tb_l_next_fill_ctrl.sv
// Directed bench for l_next_fill_ctrl: per-cycle vector table for a single miss, plus hand sequences.
module tb_l_next_fill_ctrl;
   localparam int LB = 26;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   l_next_fill_ctrl_if #(.LADDRBITS(LB), .LINEWORDS(16)) bus ();

   l_next_fill_ctrl #(.DEPTH(4), .LINEWORDS(16), .LADDRBITS(LB)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_total = 0;
   int n_pass  = 0;

   typedef struct packed {
      logic          req_valid;
      logic [LB-1:0] req_laddr;
      logic          mem_ack;
      logic          mem_rvalid;
      logic [31:0]   mem_rdata;
      logic          fill_ready;
      logic          x_req_ready;
      logic          x_mem_req;
      logic [LB-1:0] x_mem_laddr;
      logic          x_mem_rready;
      logic          x_fill_valid;
      logic [3:0]    x_fill_idx;
      logic [31:0]   x_fill_data;
      logic          x_fill_last;
      logic [31:0]   x_issue;
   } vec_t;

   localparam int NROWS = 24;
   vec_t tbl [NROWS];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic idle_in();
      bus.req_valid  = 1'b0;
      bus.req_laddr  = '0;
      bus.flush      = 1'b0;
      bus.mem_ack    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      bus.fill_ready = 1'b1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"},  bus.req_ready, 1);
      chk({tag, "_mem_rready"}, bus.mem_rready, 1);
      chk({tag, "_mem_req"},    {bus.mem_req, bus.mem_laddr}, 0);
      chk({tag, "_fill"},       {bus.fill_valid, bus.fill_last, bus.fill_idx, bus.fill_laddr, bus.fill_data}, 0);
      chk({tag, "_counts"},     {bus.issue_count, bus.merge_count}, 0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      idle_in();
      #1;
      chk_reset_outputs("rst");
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Called at a falling edge; returns at the falling edge after the accepting clock edge.
   task automatic send_req(input logic [LB-1:0] la);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_laddr = la;
      #1;
      while (!bus.req_ready && n < 100) begin
         @(negedge clock);
         #1;
         n++;
      end
      chk("req_accept", bus.req_ready, 1);
      @(negedge clock);
      bus.req_valid = 1'b0;
   endtask

   task automatic issue_ack(input logic [LB-1:0] la, input int ack_dly);
      int n = 0;
      #1;
      while (!bus.mem_req && n < 100) begin
         @(negedge clock);
         #1;
         n++;
      end
      chk("mem_req_seen", bus.mem_req, 1);
      chk("mem_laddr", bus.mem_laddr, la);
      for (int d = 0; d < ack_dly; d++) begin
         @(negedge clock);
         #1;
         chk("mem_req_hold", {bus.mem_req, bus.mem_laddr}, {1'b1, la});
      end
      @(negedge clock);
      bus.mem_ack = 1'b1;
      @(negedge clock);
      bus.mem_ack = 1'b0;
   endtask

   // Memory always offers a beat; fill_ready optionally alternates 1/0.
   task automatic serve_burst(input logic [LB-1:0] la, input int ack_dly, input bit toggle);
      bit fv_m = 1'b0;
      bit fr;
      bit xfer;
      int sent = 0;
      int got  = 0;
      issue_ack(la, ack_dly);
      for (int c = 0; c < 200 && got < 16; c++) begin
         fr             = toggle ? (c % 2 == 0) : 1'b1;
         bus.fill_ready = fr;
         bus.mem_rvalid = (sent < 16);
         bus.mem_rdata  = {la[15:0], 16'(sent)};
         #1;
         chk("mem_rready_rule", bus.mem_rready, (!fv_m || fr));
         chk("fill_valid", bus.fill_valid, fv_m);
         if (fv_m && fr) begin
            chk("fill_beat", {bus.fill_laddr, bus.fill_idx, bus.fill_data, bus.fill_last},
                {la, 4'(got), la[15:0], 16'(got), (got == 15)});
            got++;
         end
         xfer = (sent < 16) && (!fv_m || fr);
         if (xfer) begin
            fv_m = 1'b1;
            sent++;
         end else if (fr) begin
            fv_m = 1'b0;
         end
         @(negedge clock);
      end
      bus.mem_rvalid = 1'b0;
      bus.fill_ready = 1'b1;
      chk("burst_beats", got, 16);
   endtask

   task automatic expect_no_req(input string name, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         #1;
         chk(name, bus.mem_req, 0);
         @(negedge clock);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_in();

      // Single miss 0x123: ack in the 3rd REQ cycle, 16 beats of data = index.
      for (int r = 0; r < NROWS; r++) begin
         tbl[r]              = '0;
         tbl[r].fill_ready   = 1'b1;
         tbl[r].x_req_ready  = 1'b1;
         tbl[r].x_mem_rready = 1'b1;
         if (r >= 1) tbl[r].x_mem_laddr = 26'h123;
         if (r >= 4) tbl[r].x_issue = 32'd1;
      end
      tbl[0].req_valid = 1'b1;
      tbl[0].req_laddr = 26'h123;
      for (int r = 1; r <= 3; r++) tbl[r].x_mem_req = 1'b1;
      tbl[1].mem_rvalid  = 1'b1;
      tbl[1].mem_rdata   = 32'hDEAD;
      tbl[2].mem_rvalid  = 1'b1;
      tbl[2].mem_rdata   = 32'hDEAD;
      tbl[3].mem_ack     = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tbl[4+i].mem_rvalid   = 1'b1;
         tbl[4+i].mem_rdata    = 32'(i);
         tbl[5+i].x_fill_valid = 1'b1;
         tbl[5+i].x_fill_idx   = 4'(i);
         tbl[5+i].x_fill_data  = 32'(i);
         tbl[5+i].x_fill_last  = (i == 15);
      end
      tbl[20].mem_rvalid = 1'b1;
      tbl[20].mem_rdata  = 32'hBEEF;

      do_reset();
      for (int r = 0; r < NROWS; r++) begin
         @(negedge clock);
         bus.req_valid  = tbl[r].req_valid;
         bus.req_laddr  = tbl[r].req_laddr;
         bus.mem_ack    = tbl[r].mem_ack;
         bus.mem_rvalid = tbl[r].mem_rvalid;
         bus.mem_rdata  = tbl[r].mem_rdata;
         bus.fill_ready = tbl[r].fill_ready;
         #1;
         chk($sformatf("tbl%0d_req_ready", r), bus.req_ready, tbl[r].x_req_ready);
         chk($sformatf("tbl%0d_mem_req", r), {bus.mem_req, bus.mem_laddr}, {tbl[r].x_mem_req, tbl[r].x_mem_laddr});
         chk($sformatf("tbl%0d_mem_rready", r), bus.mem_rready, tbl[r].x_mem_rready);
         chk($sformatf("tbl%0d_fill_valid", r), bus.fill_valid, tbl[r].x_fill_valid);
         chk($sformatf("tbl%0d_issue", r), bus.issue_count, tbl[r].x_issue);
         if (tbl[r].x_fill_valid)
            chk($sformatf("tbl%0d_fill_beat", r),
                {bus.fill_laddr, bus.fill_idx, bus.fill_data, bus.fill_last},
                {26'h123, tbl[r].x_fill_idx, tbl[r].x_fill_data, tbl[r].x_fill_last});
      end
      idle_in();

      // Merge: 0x5 re-requested during its own DATA phase, then 0x9.
      do_reset();
      send_req(26'h5);
      fork
         serve_burst(26'h5, 0, 1'b0);
         begin
            repeat (6) @(negedge clock);
            send_req(26'h5);
            send_req(26'h9);
         end
      join
      serve_burst(26'h9, 0, 1'b0);
      expect_no_req("merge_no_extra_req", 3);
      chk("merge_counts", {bus.issue_count, bus.merge_count}, {32'd2, 32'd1});

      // Full queue with mem_ack held low; fifth request stalls until the head pops.
      do_reset();
      for (int k = 0; k < 4; k++) send_req(LB'(26'h11 + k));
      #1;
      chk("full_req_ready", bus.req_ready, 0);
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         bus.req_valid = 1'b1;
         bus.req_laddr = 26'h15;
         #1;
         chk("full_stall", bus.req_ready, 0);
         @(negedge clock);
      end
      fork
         serve_burst(26'h11, 2, 1'b1);
         send_req(26'h15);
      join
      for (int k = 2; k <= 5; k++) serve_burst(LB'(26'h10 + k), 0, (k % 2 == 0));
      expect_no_req("full_drained", 3);
      chk("full_counts", {bus.issue_count, bus.merge_count}, {32'd5, 32'd0});

      // Flush while 0x1 is awaiting ack: 0x2/0x3 are dropped.
      do_reset();
      send_req(26'h1);
      send_req(26'h2);
      send_req(26'h3);
      bus.flush = 1'b1;
      @(negedge clock);
      bus.flush = 1'b0;
      serve_burst(26'h1, 1, 1'b0);
      expect_no_req("flush_no_req", 4);
      chk("flush_issue", bus.issue_count, 1);
      send_req(26'h2);
      serve_burst(26'h2, 0, 1'b0);
      chk("flush_requeue", {bus.issue_count, bus.merge_count}, {32'd2, 32'd0});

      // Flush coincident with a request for an address being flushed: it enqueues.
      send_req(26'h4);
      send_req(26'h7);
      bus.flush = 1'b1;
      send_req(26'h7);
      bus.flush = 1'b0;
      serve_burst(26'h4, 0, 1'b0);
      serve_burst(26'h7, 0, 1'b0);
      expect_no_req("flush_accept_no_extra", 3);
      chk("flush_accept_counts", {bus.issue_count, bus.merge_count}, {32'd4, 32'd0});

      // Asynchronous reset in the middle of a burst, right after beat 7.
      do_reset();
      send_req(26'h30);
      issue_ack(26'h30, 0);
      for (int b = 0; b < 8; b++) begin
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = 32'(b);
         @(negedge clock);
      end
      #1;
      chk("pre_reset_beat", {bus.fill_valid, bus.fill_idx, bus.fill_data}, {1'b1, 4'd7, 32'd7});
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("post_reset_ignored", {bus.fill_valid, bus.mem_req}, 0);
         @(negedge clock);
      end
      bus.mem_rvalid = 1'b0;
      send_req(26'hA);
      serve_burst(26'hA, 0, 1'b0);
      chk("post_reset_issue", bus.issue_count, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/l_next_fill_ctrl.md
Name: l_next_fill_ctrl

Overview:
- Downstream companion of the L1 instruction cache: consumes its READ_OUT miss requests (26-bit line address, add_in[31:6]) and turns them into burst reads on the next-level memory port.
- Queues outstanding misses and merges duplicate line addresses.
- Streams returned words back to the cache fill port through a one-beat output register.
- Keeps issue and merge statistics for end-of-run reporting.

Parameters:
- DEPTH, 4, miss-queue entries; power of two, at least 2.
- LINEWORDS, 16, 32-bit words per line = beats per burst; power of two.
- LADDRBITS, 26, line-address width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  miss request from cache
- req_ready  out  1  queue can accept (= !full)
- req_laddr  in  LADDRBITS  missing line address
- flush  in  1  cache RESET seen: discard queued, not-yet-issued entries
- mem_req  out  1  burst read request
- mem_ack  in  1  memory accepted request
- mem_laddr  out  LADDRBITS  burst line address
- mem_rvalid  in  1  read beat valid
- mem_rready  out  1  = !fill_valid || fill_ready
- mem_rdata  in  32  read beat data
- fill_valid  out  1  fill beat valid
- fill_ready  in  1  cache accepts beat
- fill_laddr  out  LADDRBITS  line being filled
- fill_idx  out  $clog2(LINEWORDS)  word index in line
- fill_data  out  32  word
- fill_last  out  1  final beat of line
- issue_count  out  32  bursts issued (wraps)
- merge_count  out  32  requests merged (wraps)

Behaviour:
- Reset (async, reset_n=0):
  - Queue empty; FSM in IDLE; beat counter 0.
  - All outputs 0, except req_ready=1 and mem_rready=1.
  - Counters 0.
  - In-flight burst is abandoned; any further memory beats are ignored until the next mem_req.
- Accept:
  - A request is accepted on a cycle with req_valid && req_ready.
  - If req_laddr equals the laddr of any valid entry (including the in-flight head), the request is not enqueued and merge_count increments.
  - Otherwise it is written at the tail.
  - While full, req_ready=0 even if a pop happens that same cycle.
- FSM IDLE:
  - Queue non-empty → REQ next cycle.
  - mem_laddr = head laddr; mem_req=1 from the first REQ cycle.
- FSM REQ:
  - Hold mem_req and mem_laddr stable until mem_ack.
  - On mem_ack: issue_count++, beat counter cleared, → DATA.
  - Minimum latency from accept into an empty queue to mem_req = 1 cycle.
- FSM DATA:
  - A beat transfers when mem_rvalid && mem_rready.
  - On transfer the beat is registered into fill_data; fill_idx = beat counter; fill_laddr = head laddr; fill_last = (counter == LINEWORDS-1); fill_valid=1; counter increments.
  - fill_valid clears on fill_ready unless a new beat loads the same cycle.
  - After the last beat is captured: head popped, → IDLE.
  - The last fill beat may still be pending in the output register while the next request starts.
- Back-to-back: full throughput of one beat/cycle when fill_ready is held high.
- Flush:
  - Clears all entries except the in-flight head (REQ/DATA).
  - In IDLE, flush empties the queue.
  - Flush coincident with accept: the flush applies first, then the accept enqueues.
  - Merge check excludes flushed entries.
- Pointers wrap modulo DEPTH. full/empty are derived from an occupancy count of 0..DEPTH.
- mem_rvalid outside DATA is ignored.

Test Plan:
- Single miss: reset, req laddr=0x0000123 → mem_req next cycle; ack after 3 cycles; 16 beats data=i → fill_idx 0..15, fill_last on idx 15, issue_count=1, queue empty.
- Merge: laddr 0x5, then 0x5 again during DATA, then 0x9 → one 0x5 burst then one 0x9 burst; merge_count=1, issue_count=2.
- Full/backpressure: DEPTH=4, mem_ack held 0, five distinct requests → req_ready=0 after the 4th, 5th stalls; fill_ready toggled 1/0 during DATA → no beat lost or duplicated, mem_rready tracks the rule.
- Flush: queue 0x1(in flight),0x2,0x3, pulse flush → only 0x1 completes; then 0x2 re-requested is enqueued (not merged).
- Async reset mid-DATA at beat 7 → outputs cleared immediately; after release, new request 0xA completes a full 16-beat line with fill_idx starting at 0.
